// File: rtl/adc_capture_sync.sv
// adc_capture_sync: fires NUM_CH ADCs on one trigger, latches/clamps/rescales each as it finishes.
// Latency: eoc_o pulses one cycle after the last channel is captured; rate_o refreshes every CLK_HZ cycles.
// Backpressure: none; start_i is dropped while busy. ADC_TIMEOUT_EN adds a watchdog reporting stuck channels on err_o.
module adc_capture_sync #(
   parameter int NUM_CH      = 2,
   parameter int IN_W        = 16,
   parameter int OUT_W       = 12,
   parameter int CLK_HZ      = 27000000,
   parameter int TIMEOUT_CYC = 65535
) (
   input  logic                    clk_i,
   input  logic                    rst_ni,
   input  logic                    start_i,
   input  logic [NUM_CH-1:0]       ch_ready_i,
   input  logic [NUM_CH*IN_W-1:0]  ch_data_i,
   output logic [NUM_CH-1:0]       ch_enable_o,
   output logic [NUM_CH*OUT_W-1:0] sample_o,
   output logic                    eoc_o,
   output logic                    busy_o,
   output logic [NUM_CH-1:0]       err_o,
   output logic [15:0]             rate_o,
   output logic                    rate_valid_o
);

   typedef enum logic [1:0] {IDLE, WAIT_ACK, CAPTURE} state_t;

   localparam int WIN_W = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;

   state_t            state;
   logic [NUM_CH-1:0] done;
   logic [NUM_CH-1:0] cap;
   logic              timeout;
   logic [WIN_W-1:0]  win_cnt;
   logic [15:0]       ev_cnt;
   logic              unused_lsbs;

   // Raw bits below the output precision are deliberately discarded.
   assign unused_lsbs = ^ch_data_i;

   function automatic logic [OUT_W-1:0] scale(input logic [IN_W-1:0] raw);
      return raw[IN_W-1] ? '0 : raw[IN_W-2 -: OUT_W];
   endfunction

`ifdef ADC_TIMEOUT_EN
   localparam int TO_W = $clog2(TIMEOUT_CYC + 1);

   logic [TO_W-1:0]   to_cnt;
   logic [NUM_CH-1:0] err_q;

   // Fires on the cycle that makes eoc_o land exactly TIMEOUT_CYC cycles after the trigger.
   assign timeout = (state != IDLE) && (to_cnt == TO_W'(TIMEOUT_CYC - 1));
   assign err_o   = err_q;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         to_cnt <= '0;
         err_q  <= '0;
      end else begin
         if (state == IDLE) to_cnt <= '0;
         else               to_cnt <= to_cnt + TO_W'(1);
         if (state == IDLE && start_i) err_q <= '0;
         else if (timeout)             err_q <= ~done;
      end
   end
`else
   logic unused_timeout;

   assign timeout        = 1'b0;
   assign err_o          = '0;
   assign unused_timeout = (TIMEOUT_CYC == 0);
`endif

   assign cap = (state == CAPTURE && !timeout) ? (ch_ready_i & ~done) : '0;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state       <= IDLE;
         ch_enable_o <= '0;
         done        <= '0;
         eoc_o       <= 1'b0;
         busy_o      <= 1'b0;
      end else begin
         eoc_o <= 1'b0;
         case (state)
            IDLE: begin
               if (start_i) begin
                  state       <= WAIT_ACK;
                  busy_o      <= 1'b1;
                  ch_enable_o <= '1;
                  done        <= '0;
               end
            end
            WAIT_ACK: begin
               if (timeout) begin
                  state       <= IDLE;
                  busy_o      <= 1'b0;
                  eoc_o       <= 1'b1;
                  ch_enable_o <= '0;
               end else if (ch_ready_i == '0) begin
                  // Every channel must be seen busy so a stale ready from the last set is not taken as fresh.
                  state <= CAPTURE;
               end
            end
            CAPTURE: begin
               if ((&done) || timeout) begin
                  state       <= IDLE;
                  busy_o      <= 1'b0;
                  eoc_o       <= 1'b1;
                  ch_enable_o <= '0;
               end else begin
                  done        <= done | cap;
                  ch_enable_o <= ch_enable_o & ~cap;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         sample_o <= '0;
      end else begin
         for (int k = 0; k < NUM_CH; k++) begin
            if (cap[k]) sample_o[k*OUT_W +: OUT_W] <= scale(ch_data_i[k*IN_W +: IN_W]);
         end
      end
   end

   // An eoc_o landing on the window-end cycle is credited to the window that starts there.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         win_cnt      <= '0;
         ev_cnt       <= '0;
         rate_o       <= '0;
         rate_valid_o <= 1'b0;
      end else begin
         rate_valid_o <= 1'b0;
         if (win_cnt == WIN_W'(CLK_HZ - 1)) begin
            win_cnt      <= '0;
            rate_o       <= ev_cnt;
            rate_valid_o <= 1'b1;
            ev_cnt       <= {15'd0, eoc_o};
         end else begin
            win_cnt <= win_cnt + WIN_W'(1);
            if (eoc_o && ev_cnt != 16'hFFFF) ev_cnt <= ev_cnt + 16'd1;
         end
      end
   end

endmodule

// File: tb/tb_adc_capture_sync.sv
// Directed bench for adc_capture_sync: behavioural model checked every cycle plus hand-computed literals.
module tb_adc_capture_sync;

   localparam int NUM_CH = 2;
   localparam int IN_W   = 16;
   localparam int OUT_W  = 12;
   localparam int CLK_HZ = 1000;
   localparam int TO_CYC = 50;
`ifdef ADC_TIMEOUT_EN
   localparam bit TO_EN = 1'b1;
`else
   localparam bit TO_EN = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        start = 1'b0;
   logic [1:0]  ready = 2'b00;
   logic [15:0] d0 = '0, d1 = '0;
   logic [31:0] data;
   logic [1:0]  en, err;
   logic [23:0] smp;
   logic        eoc, busy, rv;
   logic [15:0] rate;

   int n_chk = 0;
   int n_fail = 0;

   assign data = {d1, d0};

   always #5 clk = ~clk;

   adc_capture_sync #(
      .NUM_CH(NUM_CH), .IN_W(IN_W), .OUT_W(OUT_W), .CLK_HZ(CLK_HZ), .TIMEOUT_CYC(TO_CYC)
   ) dut (
      .clk_i(clk), .rst_ni(rst_n), .start_i(start), .ch_ready_i(ready), .ch_data_i(data),
      .ch_enable_o(en), .sample_o(smp), .eoc_o(eoc), .busy_o(busy), .err_o(err),
      .rate_o(rate), .rate_valid_o(rv)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   bit         m_busy, m_armed, m_eoc, m_rv;
   logic [1:0] m_en, m_done, m_err;
   logic [11:0] m_smp [NUM_CH];
   int         m_age, m_win;
   logic [15:0] m_ev, m_rate;

   function automatic logic [11:0] to_sample(input logic [15:0] raw);
      if ($signed(raw) < 0) return 12'd0;
      return 12'(raw / (1 << (IN_W - 1 - OUT_W)));
   endfunction

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_busy = 0; m_armed = 0; m_eoc = 0; m_rv = 0;
         m_en = '0; m_done = '0; m_err = '0; m_age = 0; m_win = 0;
         m_ev = '0; m_rate = '0;
         for (int k = 0; k < NUM_CH; k++) m_smp[k] = '0;
      end else begin
         bit prev_eoc;
         prev_eoc = m_eoc;
         m_eoc = 0;
         m_rv = 0;
         if (m_win == CLK_HZ - 1) begin
            m_win = 0; m_rate = m_ev; m_rv = 1; m_ev = prev_eoc ? 16'd1 : 16'd0;
         end else begin
            m_win++;
            if (prev_eoc && m_ev != 16'hFFFF) m_ev++;
         end
         if (!m_busy) begin
            if (start) begin
               m_busy = 1; m_armed = 0; m_en = '1; m_done = '0; m_err = '0; m_age = 0;
            end
         end else begin
            if (&m_done) begin
               m_busy = 0; m_eoc = 1;
            end else if (TO_EN && m_age == TO_CYC - 1) begin
               m_err = ~m_done; m_en = '0; m_busy = 0; m_eoc = 1;
            end else if (!m_armed) begin
               m_armed = (ready == 2'b00);
            end else begin
               for (int k = 0; k < NUM_CH; k++) begin
                  if (ready[k] && !m_done[k]) begin
                     m_smp[k] = to_sample(data[k*IN_W +: IN_W]);
                     m_en[k] = 1'b0;
                     m_done[k] = 1'b1;
                  end
               end
            end
            m_age++;
         end
      end
   end

   always @(negedge clk) begin
      if (rst_n) begin
         logic [23:0] es;
         for (int k = 0; k < NUM_CH; k++) es[k*OUT_W +: OUT_W] = m_smp[k];
         chk("model_enable", 32'(en), 32'(m_en));
         chk("model_sample", 32'(smp), 32'(es));
         chk("model_eoc", 32'(eoc), 32'(m_eoc));
         chk("model_busy", 32'(busy), 32'(m_busy));
         chk("model_err", 32'(err), 32'(m_err));
         chk("model_rate", 32'(rate), 32'(m_rate));
         chk("model_rate_valid", 32'(rv), 32'(m_rv));
      end
   end

   // ---------------- stimulus ----------------
   task automatic cyc(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic wait_eoc(input int max, output int n);
      n = 0;
      while (!eoc && n < max) begin
         @(negedge clk);
         n++;
      end
      if (!eoc) begin
         n_chk++;
         n_fail++;
         $display("FAIL wait_eoc: no eoc_o within %0d cycles, expected a pulse", max);
      end
   endtask

   // Exactly 6 cycles from trigger to return; eoc_o is seen on the 5th negedge.
   task automatic conv();
      start = 1'b1; cyc(1);
      start = 1'b0; ready = 2'b00; cyc(2);
      ready = 2'b11; cyc(3);
   endtask

   initial begin
      int n, cnt;
      cyc(2);
      chk("rst_enable", 32'(en), 0);
      chk("rst_sample", 32'(smp), 0);
      chk("rst_eoc", 32'(eoc), 0);
      chk("rst_busy", 32'(busy), 0);
      chk("rst_err", 32'(err), 0);
      chk("rst_rate", 32'(rate), 0);
      chk("rst_rate_valid", 32'(rv), 0);
      rst_n = 1'b1;
      cyc(2);

      // Both channels complete together
      d0 = 16'h2000; d1 = 16'h4CCE;
      start = 1'b1; cyc(1);
      start = 1'b0; cyc(2);
      ready = 2'b11; cyc(1);
      chk("t1_enable_dropped", 32'(en), 0);
      chk("t1_eoc_not_yet", 32'(eoc), 0);
      cyc(1);
      chk("t1_eoc", 32'(eoc), 1);
      chk("t1_sample", 32'(smp), 32'h999400);
      ready = 2'b00; cyc(2);

      // Ch0 finishes 10 cycles before ch1
      start = 1'b1; cyc(1);
      start = 1'b0; cyc(1);
      ready = 2'b01; d0 = 16'h1238; cyc(1);
      chk("t2_enable_ch0_first", 32'(en), 32'b10);
      d0 = 16'h7FF8; cyc(10);
      chk("t2_ch0_held", 32'(smp[11:0]), 32'h247);
      chk("t2_no_eoc", 32'(eoc), 0);
      ready = 2'b11; d1 = 16'h0010;
      wait_eoc(5, n);
      chk("t2_eoc_latency", n, 2);
      chk("t2_sample", 32'(smp), 32'h002247);

      // Stale ready held through the trigger
      d0 = 16'h0808; d1 = 16'h3FF8;
      start = 1'b1; cyc(1);
      start = 1'b0; cyc(5);
      chk("t3_still_waiting", 32'(busy), 1);
      chk("t3_enable_held", 32'(en), 32'b11);
      chk("t3_no_capture", 32'(smp), 32'h002247);
      ready = 2'b00; cyc(1);
      ready = 2'b11;
      wait_eoc(5, n);
      chk("t3_eoc_latency", n, 2);
      chk("t3_sample", 32'(smp), 32'h7FF101);

      // Negative code clamps; start during CAPTURE is ignored
      d0 = 16'h0100; d1 = 16'hFFF0;
      start = 1'b1; cyc(1);
      start = 1'b0; ready = 2'b00; cyc(1);
      ready = 2'b01; cyc(1);
      start = 1'b1; cyc(1);
      start = 1'b0; cyc(1);
      ready = 2'b11;
      cnt = 0;
      for (int i = 0; i < 8; i++) begin
         cyc(1);
         if (eoc) cnt++;
      end
      chk("t4_single_eoc", cnt, 1);
      chk("t4_sample_clamped", 32'(smp), 32'h000020);

      // start_i on the eoc_o cycle is accepted
      start = 1'b1; cyc(1);
      start = 1'b0; ready = 2'b00; cyc(1);
      ready = 2'b11;
      wait_eoc(5, n);
      start = 1'b1; cyc(1);
      start = 1'b0;
      chk("t5_start_on_eoc", 32'(busy), 1);
      ready = 2'b00; cyc(1);
      ready = 2'b11;
      wait_eoc(5, n);
      cyc(1);

      // Rate meter: align to a window end, then 10 triggers plus one on the boundary
      d0 = 16'h2000; d1 = 16'h4CCE;
      n = 0;
      while (!rv && n < 1100) begin
         cyc(1);
         n++;
      end
      if (!rv) begin
         n_chk++;
         n_fail++;
         $display("FAIL rate_align: no rate_valid_o within %0d cycles, expected one", n);
      end
      for (int i = 0; i < 10; i++) begin
         conv();
         cyc(i == 9 ? 88 : 94);
      end
      conv();
      chk("rate_window1_valid", 32'(rv), 1);
      chk("rate_window1", 32'(rate), 10);
      cyc(100); conv();
      cyc(94);  conv();
      cyc(794);
      chk("rate_window2_valid", 32'(rv), 1);
      chk("rate_window2", 32'(rate), 3);

`ifdef ADC_TIMEOUT_EN
      // Ch1 never reports ready
      ready = 2'b00; cyc(1);
      d1 = 16'h7FF8;
      start = 1'b1; cyc(1);
      start = 1'b0; cyc(2);
      ready = 2'b01; d0 = 16'h1000;
      wait_eoc(60, n);
      chk("to_eoc_at_50", n + 2, TO_CYC);
      chk("to_err", 32'(err), 32'b10);
      chk("to_sample_held", 32'(smp), 32'h999200);
      chk("to_enable", 32'(en), 0);
      ready = 2'b00;
      cyc(1);
      start = 1'b1; cyc(1);
      start = 1'b0;
      chk("to_err_cleared", 32'(err), 0);
      cyc(1);
      ready = 2'b11;
      wait_eoc(5, n);
      cyc(1);
`endif

      // Reset mid-conversion drops enables at once
      start = 1'b1; cyc(1);
      start = 1'b0; ready = 2'b00; cyc(2);
      rst_n = 1'b0;
      #1;
      chk("arst_enable", 32'(en), 0);
      chk("arst_busy", 32'(busy), 0);
      chk("arst_sample", 32'(smp), 0);
      cyc(2);
      rst_n = 1'b1;
      cyc(3);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
